fetch_unit: RTL and testbench

//   Instruction fetch stage upstream of the control/decode block. Owns the PC register
//   and issues one request at a time to instruction memory over a req/ready +

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// holds the returned word for decode. Redirects squash any in-flight or held fetch.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] pctarget,
  output logic [31:0]     fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_FULL
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_pc_q;
  logic [XLEN-1:0] w_pc_q_next;
  logic            r_kill;
  logic            w_kill_next;
  logic [31:0]     r_fetch_cnt;
  logic [31:0]     w_fetch_cnt_next;
  logic            w_capture;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pcplus4;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_redirect_pc = pctarget & ~XLEN'(3);

  always_comb begin
    w_state_next     = r_state;
    w_pc_q_next      = r_pc_q;
    w_kill_next      = r_kill;
    w_fetch_cnt_next = r_fetch_cnt;
    w_capture        = 1'b0;
    case (r_state)
      S_BOOT: w_state_next = S_REQ;
      S_REQ: begin
        // The old-address request still goes out; its response must be dropped.
        if (imem_ready) begin
          w_state_next = S_WAIT;
          if (pcsrc) w_kill_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_kill_next = 1'b0;
          if (!r_kill && !pcsrc) begin
            w_capture    = 1'b1;
            w_state_next = S_FULL;
          end else begin
            w_state_next = S_REQ;
          end
        end else if (pcsrc) begin
          w_kill_next = 1'b1;
        end
      end
      S_FULL: begin
        if (instr_ready) begin
          w_fetch_cnt_next = r_fetch_cnt + 32'd1;
          w_pc_q_next      = r_pc_q + XLEN'(4);
          w_state_next     = S_REQ;
        end
        if (pcsrc) w_state_next = S_REQ;
      end
      default: w_state_next = S_BOOT;
    endcase
    if (pcsrc) w_pc_q_next = w_redirect_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_BOOT;
      r_pc_q      <= RESET_PC;
      r_kill      <= 1'b0;
      r_fetch_cnt <= '0;
      r_instr     <= '0;
      r_pc        <= RESET_PC;
      r_pcplus4   <= RESET_PC + XLEN'(4);
    end else begin
      r_state     <= w_state_next;
      r_pc_q      <= w_pc_q_next;
      r_kill      <= w_kill_next;
      r_fetch_cnt <= w_fetch_cnt_next;
      if (w_capture) begin
        r_instr   <= imem_rdata;
        r_pc      <= r_pc_q;
        r_pcplus4 <= r_pc_q + XLEN'(4);
      end
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc_q;
  assign instr_valid = (r_state == S_FULL);
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign pcplus4     = r_pcplus4;
  assign fetch_cnt   = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs driven after the falling edge,
// outputs sampled on the falling edge, imem and decode modelled cycle by cycle.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        pcsrc;
  logic [31:0] pctarget;
  logic [31:0] fetch_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .pc(pc), .pcplus4(pcplus4), .pcsrc(pcsrc), .pctarget(pctarget),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // One full REQ -> WAIT -> FULL round trip with a 1-cycle imem; leaves DUT in FULL.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input string tag);
    logic [31:0] exp_p4;
    exp_p4 = addr + 32'd4;
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== addr) begin
      err_cnt++;
      $display("FAIL %s_req: got req=%b addr=%h, expected req=1 addr=%h", tag, imem_req, imem_addr, addr);
    end
    $display("%s: request addr=%h", tag, imem_addr);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    vec_cnt++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_wait: got req=%b valid=%b, expected req=0 valid=0", tag, imem_req, instr_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    vec_cnt++;
    if (instr_valid !== 1'b1 || instr !== data || pc !== addr || pcplus4 !== exp_p4) begin
      err_cnt++;
      $display("FAIL %s_full: got valid=%b instr=%h pc=%h pc4=%h, expected valid=1 instr=%h pc=%h pc4=%h",
               tag, instr_valid, instr, pc, pcplus4, data, addr, exp_p4);
    end
    $display("%s: delivered instr=%h pc=%h", tag, instr, pc);
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; pcsrc = 1'b0; pctarget = '0;
    step(); step();
    vec_cnt++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || pcplus4 !== 32'h4 ||
        fetch_cnt !== 32'h0 || instr !== 32'h0 || imem_addr !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_state: got req=%b valid=%b pc=%h pc4=%h cnt=%0d instr=%h addr=%h, expected 0,0,0,4,0,0,0",
               imem_req, instr_valid, pc, pcplus4, fetch_cnt, instr, imem_addr);
    end
    reset = 1'b0;
    step();
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      err_cnt++;
      $display("FAIL boot_to_req: got req=%b addr=%h, expected req=1 addr=00000000", imem_req, imem_addr);
    end
    $display("reset: released, req=%b addr=%h", imem_req, imem_addr);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      fetch_one(32'(4 * i), 32'h0010_0093 + 32'(i << 8), "basic");
      consume();
    end
    vec_cnt++;
    if (fetch_cnt !== 32'd3 || imem_addr !== 32'hC || imem_req !== 1'b1) begin
      err_cnt++;
      $display("FAIL basic_count: got cnt=%0d addr=%h req=%b, expected cnt=3 addr=0000000c req=1",
               fetch_cnt, imem_addr, imem_req);
    end
  endtask

  task automatic test_decode_stall();
    fetch_one(32'hC, 32'hCAFE_0013, "stall");
    for (int i = 0; i < 5; i++) begin
      step();
      vec_cnt++;
      if (instr_valid !== 1'b1 || instr !== 32'hCAFE_0013 || pc !== 32'hC ||
          imem_req !== 1'b0 || fetch_cnt !== 32'd3) begin
        err_cnt++;
        $display("FAIL stall_hold: got valid=%b instr=%h pc=%h req=%b cnt=%0d, expected 1,cafe0013,0000000c,0,3",
                 instr_valid, instr, pc, imem_req, fetch_cnt);
      end
    end
    consume();
    vec_cnt++;
    if (fetch_cnt !== 32'd4 || imem_addr !== 32'h10) begin
      err_cnt++;
      $display("FAIL stall_release: got cnt=%0d addr=%h, expected cnt=4 addr=00000010", fetch_cnt, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    pcsrc = 1'b1; pctarget = 32'h103;
    step();
    pcsrc = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    vec_cnt++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_cnt !== 32'd4) begin
      err_cnt++;
      $display("FAIL kill_wait: got valid=%b req=%b addr=%h cnt=%0d, expected 0,1,00000100,4",
               instr_valid, imem_req, imem_addr, fetch_cnt);
    end
    $display("redirect_wait: stale word dropped, next addr=%h", imem_addr);
    // Redirect coincident with the response itself.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001; pcsrc = 1'b1; pctarget = 32'h20;
    step();
    imem_rvalid = 1'b0; pcsrc = 1'b0;
    vec_cnt++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      err_cnt++;
      $display("FAIL kill_rvalid: got valid=%b req=%b addr=%h, expected 0,1,00000020",
               instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_full();
    fetch_one(32'h20, 32'h0040_0113, "redir_full");
    instr_ready = 1'b1; pcsrc = 1'b1; pctarget = 32'h80;
    step();
    instr_ready = 1'b0; pcsrc = 1'b0;
    vec_cnt++;
    if (instr_valid !== 1'b0 || fetch_cnt !== 32'd5 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      err_cnt++;
      $display("FAIL redirect_full: got valid=%b cnt=%0d req=%b addr=%h, expected 0,5,1,00000080",
               instr_valid, fetch_cnt, imem_req, imem_addr);
    end
  endtask

  task automatic test_imem_stall();
    for (int i = 0; i < 4; i++) begin
      step();
      vec_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
        err_cnt++;
        $display("FAIL imem_stall: got req=%b addr=%h, expected req=1 addr=00000080", imem_req, imem_addr);
      end
    end
    pcsrc = 1'b1; pctarget = 32'h200;
    step();
    pcsrc = 1'b0;
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      err_cnt++;
      $display("FAIL stall_redirect: got req=%b addr=%h, expected req=1 addr=00000200", imem_req, imem_addr);
    end
    fetch_one(32'h200, 32'h00C0_0193, "stall_redir");
    consume();
    vec_cnt++;
    if (fetch_cnt !== 32'd6 || imem_addr !== 32'h204) begin
      err_cnt++;
      $display("FAIL stall_next: got cnt=%0d addr=%h, expected cnt=6 addr=00000204", fetch_cnt, imem_addr);
    end
  endtask

  task automatic test_wrap();
    pcsrc = 1'b1; pctarget = 32'hFFFF_FFFE;
    step();
    pcsrc = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h0000_0073, "wrap");
    consume();
    vec_cnt++;
    if (fetch_cnt !== 32'd7 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      err_cnt++;
      $display("FAIL wrap_next: got cnt=%0d addr=%h req=%b, expected cnt=7 addr=00000000 req=1",
               fetch_cnt, imem_addr, imem_req);
    end
  endtask

  task automatic test_reset_in_wait();
    pcsrc = 1'b1; pctarget = 32'h40;
    step();
    pcsrc = 1'b0;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    vec_cnt++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || imem_addr !== 32'h0 ||
        fetch_cnt !== 32'h0 || instr !== 32'h0) begin
      err_cnt++;
      $display("FAIL async_reset: got req=%b valid=%b pc=%h addr=%h cnt=%0d instr=%h, expected all zero",
               imem_req, instr_valid, pc, imem_addr, fetch_cnt, instr);
    end
    step();
    reset = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
    step();
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL late_rvalid_boot: got req=%b addr=%h valid=%b, expected 1,00000000,0",
               imem_req, imem_addr, instr_valid);
    end
    step();
    imem_rvalid = 1'b0;
    vec_cnt++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0) begin
      err_cnt++;
      $display("FAIL late_rvalid_req: got req=%b valid=%b instr=%h, expected 1,0,00000000",
               imem_req, instr_valid, instr);
    end
    fetch_one(32'h0, 32'h0050_0213, "post_reset");
    consume();
    vec_cnt++;
    if (fetch_cnt !== 32'd1 || imem_addr !== 32'h4) begin
      err_cnt++;
      $display("FAIL post_reset_count: got cnt=%0d addr=%h, expected cnt=1 addr=00000004", fetch_cnt, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_full();
    test_imem_stall();
    test_wrap();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
